// File: rtl/pwm_duty_ramp.sv
// ============================================================================
// Module      : pwm_duty_ramp
// Description : Breathing-profile duty generator feeding the PWM duty input:
//               ramp up to duty_max, hold, ramp down to duty_min, hold, repeat.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_duty_ramp #(
    parameter int N      = 16,
    parameter int DIV_W  = 24,
    parameter int HOLD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N-1:0]      duty_min,
    input  logic [N-1:0]      duty_max,
    input  logic [N-1:0]      step,
    input  logic [DIV_W-1:0]  tick_div,
    input  logic [HOLD_W-1:0] hold_cnt,
    output logic [N-1:0]      duty,
    output logic              duty_upd,
    output logic [2:0]        state,
    output logic              cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_HOLD_HIGH = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_HOLD_LOW  = 3'd4
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [N-1:0]      r_duty, w_duty_nxt;
    logic              r_upd;
    logic              r_cfg_err, w_err_nxt;
    logic [DIV_W-1:0]  r_presc, w_presc_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;
    logic              w_load_cfg;

    logic [N-1:0]      r_min, r_max, r_step;
    logic [DIV_W-1:0]  r_div;
    logic [HOLD_W-1:0] r_holdc;

    logic              w_tick;
    logic              w_valid;
    logic [N:0]        w_sum;
    logic [N:0]        w_floor;
    logic [N-1:0]      w_up_val;
    logic [N-1:0]      w_dn_val;

    assign w_tick  = (r_presc == r_div);
    assign w_valid = (duty_min <= duty_max) && (step != '0);

    // Ramp arithmetic in N+1 bits so neither direction can wrap.
    assign w_sum    = {1'b0, r_duty} + {1'b0, r_step};
    assign w_floor  = {1'b0, r_min} + {1'b0, r_step};
    assign w_up_val = (w_sum >= {1'b0, r_max}) ? r_max : w_sum[N-1:0];
    assign w_dn_val = ({1'b0, r_duty} < w_floor) ? r_min : (r_duty - r_step);

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_err_nxt   = r_cfg_err;
        w_presc_nxt = r_presc;
        w_hold_nxt  = r_hold;
        w_load_cfg  = 1'b0;

        if (r_state == S_IDLE) begin
            w_presc_nxt = '0;
            w_hold_nxt  = '0;
            if (en && w_valid) begin
                w_load_cfg  = 1'b1;
                w_duty_nxt  = duty_min;
                w_state_nxt = S_RAMP_UP;
                w_err_nxt   = 1'b0;
            end else begin
                w_err_nxt = en;
            end
        end else if (!en) begin
            w_state_nxt = S_IDLE;
            w_duty_nxt  = '0;
            w_presc_nxt = '0;
            w_hold_nxt  = '0;
            w_err_nxt   = 1'b0;
        end else begin
            w_err_nxt   = 1'b0;
            w_presc_nxt = w_tick ? '0 : (r_presc + DIV_W'(1));
            if (w_tick) begin
                case (r_state)
                    S_RAMP_UP: begin
                        w_duty_nxt = w_up_val;
                        if (w_up_val == r_max) begin
                            w_state_nxt = S_HOLD_HIGH;
                            w_hold_nxt  = r_holdc;
                        end
                    end
                    S_HOLD_HIGH: begin
                        if (r_hold == '0) w_state_nxt = S_RAMP_DOWN;
                        else              w_hold_nxt  = r_hold - HOLD_W'(1);
                    end
                    S_RAMP_DOWN: begin
                        w_duty_nxt = w_dn_val;
                        if (w_dn_val == r_min) begin
                            w_state_nxt = S_HOLD_LOW;
                            w_hold_nxt  = r_holdc;
                        end
                    end
                    S_HOLD_LOW: begin
                        if (r_hold != '0) begin
                            w_hold_nxt = r_hold - HOLD_W'(1);
                        end else if (w_valid) begin
                            w_load_cfg  = 1'b1;
                            w_duty_nxt  = duty_min;
                            w_state_nxt = S_RAMP_UP;
                        end else begin
                            w_duty_nxt  = '0;
                            w_state_nxt = S_IDLE;
                            w_err_nxt   = 1'b1;
                            w_presc_nxt = '0;
                        end
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_duty    <= '0;
            r_upd     <= 1'b0;
            r_cfg_err <= 1'b0;
            r_presc   <= '0;
            r_hold    <= '0;
            r_min     <= '0;
            r_max     <= '0;
            r_step    <= '0;
            r_div     <= '0;
            r_holdc   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_duty    <= w_duty_nxt;
            r_upd     <= (w_duty_nxt != r_duty);
            r_cfg_err <= w_err_nxt;
            r_presc   <= w_presc_nxt;
            r_hold    <= w_hold_nxt;
            if (w_load_cfg) begin
                r_min   <= duty_min;
                r_max   <= duty_max;
                r_step  <= step;
                r_div   <= tick_div;
                r_holdc <= hold_cnt;
            end
        end
    end

    assign duty     = r_duty;
    assign duty_upd = r_upd;
    assign state    = r_state;
    assign cfg_err  = r_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_ramp.sv
// ============================================================================
// Module      : tb_pwm_duty_ramp
// Description : Scoreboard bench for pwm_duty_ramp against a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pwm_duty_ramp;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] duty_min, duty_max, step;
    logic [23:0] tick_div;
    logic [15:0] hold_cnt;
    logic [15:0] duty;
    logic        duty_upd;
    logic [2:0]  state;
    logic        cfg_err;

    pwm_duty_ramp #(.N(16), .DIV_W(24), .HOLD_W(16)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .duty_min (duty_min),
        .duty_max (duty_max),
        .step     (step),
        .tick_div (tick_div),
        .hold_cnt (hold_cnt),
        .duty     (duty),
        .duty_upd (duty_upd),
        .state    (state),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [15:0] d;
        logic        u;
        logic        e;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // behavioural model state (plain integers)
    int m_state, m_duty, m_pre, m_hold;
    bit m_upd, m_err;
    int s_min, s_max, s_step, s_div, s_hold;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_duty = 0; m_pre = 0; m_hold = 0;
        m_upd = 0; m_err = 0;
        s_min = 0; s_max = 0; s_step = 0; s_div = 0; s_hold = 0;
    endtask

    task automatic sample_cfg();
        s_min = duty_min; s_max = duty_max; s_step = step;
        s_div = tick_div; s_hold = hold_cnt;
    endtask

    task automatic model_step();
        bit valid, tick;
        int nd, t;
        exp_t ex;
        valid = (int'(duty_min) <= int'(duty_max)) && (step != 0);
        tick  = (m_pre == s_div);
        nd    = m_duty;
        if (m_state == 0) begin
            if (en && valid) begin
                sample_cfg();
                nd = duty_min; m_state = 1; m_pre = 0; m_err = 0;
            end else begin
                m_err = en && !valid;
            end
        end else if (!en) begin
            m_state = 0; nd = 0; m_pre = 0; m_hold = 0; m_err = 0;
        end else begin
            m_pre = tick ? 0 : m_pre + 1;
            if (tick) begin
                case (m_state)
                    1: begin
                        t = m_duty + s_step;
                        if (t > s_max) t = s_max;
                        nd = t;
                        if (t == s_max) begin m_state = 2; m_hold = s_hold; end
                    end
                    2: if (m_hold == 0) m_state = 3; else m_hold--;
                    3: begin
                        nd = (m_duty < s_min + s_step) ? s_min : m_duty - s_step;
                        if (nd == s_min) begin m_state = 4; m_hold = s_hold; end
                    end
                    default: begin
                        if (m_hold != 0) m_hold--;
                        else if (valid) begin
                            sample_cfg(); m_state = 1; nd = duty_min;
                        end else begin
                            m_state = 0; nd = 0; m_err = 1; m_pre = 0;
                        end
                    end
                endcase
            end
        end
        m_upd  = (nd != m_duty);
        m_duty = nd;
        ex.st = 3'(m_state); ex.d = 16'(m_duty); ex.u = m_upd; ex.e = m_err;
        q.push_back(ex);
    endtask

    // One clock: predict, let the edge happen, compare just after it.
    task automatic cycle();
        exp_t ex;
        model_step();
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check_val("queue_empty", 32'd1, 32'd0);
        end else begin
            ex = q.pop_front();
            check_val("state",    32'(state),    32'(ex.st));
            check_val("duty",     32'(duty),     32'(ex.d));
            check_val("duty_upd", 32'(duty_upd), 32'(ex.u));
            check_val("cfg_err",  32'(cfg_err),  32'(ex.e));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_cfg(input logic [15:0] mn, input logic [15:0] mx, input logic [15:0] st,
                           input logic [23:0] dv, input logic [15:0] hd);
        duty_min = mn; duty_max = mx; step = st; tick_div = dv; hold_cnt = hd;
    endtask

    task automatic run_until(input int st, input int d, input int budget);
        int k;
        k = 0;
        while (!(m_state == st && m_duty == d) && k < budget) begin
            cycle();
            k++;
        end
        if (k >= budget) check_val("wait_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0;
        set_cfg(16'd0, 16'd0, 16'd0, 24'd0, 16'd0);
        model_reset();
        #12;
        check_val("rst_duty",  32'(duty),     32'd0);
        check_val("rst_state", 32'(state),    32'd0);
        check_val("rst_upd",   32'(duty_upd), 32'd0);
        check_val("rst_err",   32'(cfg_err),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(2);

        // basic breathing cycle
        set_cfg(16'd10, 16'd40, 16'd10, 24'd0, 16'd1);
        en = 1'b1;
        run(20);

        // clamping at both ends
        en = 1'b0; run(1);
        set_cfg(16'd0, 16'd25, 16'd10, 24'd0, 16'd0);
        en = 1'b1; run(14);

        // overflow guard near full scale
        en = 1'b0; run(1);
        set_cfg(16'hFFF0, 16'hFFFF, 16'h8000, 24'd0, 16'd0);
        en = 1'b1; run(10);

        // prescaled ramp; mid-ramp max change waits for the next cycle
        en = 1'b0; run(1);
        set_cfg(16'd0, 16'd3, 16'd1, 24'd3, 16'd0);
        en = 1'b1; run(9);
        duty_max = 16'd100;
        run(60);

        // invalid configurations
        en = 1'b0; run(1);
        set_cfg(16'd50, 16'd20, 16'd10, 24'd0, 16'd0);
        en = 1'b1; run(3);
        set_cfg(16'd10, 16'd40, 16'd0, 24'd0, 16'd0);
        run(2);
        step = 16'd10;
        run(3);

        // en drop during ramp-down at 30
        en = 1'b0; run(1);
        set_cfg(16'd10, 16'd40, 16'd10, 24'd0, 16'd1);
        en = 1'b1;
        run_until(3, 30, 40);
        en = 1'b0; run(3);

        // asynchronous reset mid ramp-up
        en = 1'b1; run(3);
        #2 rst = 1'b1;
        #1;
        check_val("arst_duty",  32'(duty),     32'd0);
        check_val("arst_state", 32'(state),    32'd0);
        check_val("arst_upd",   32'(duty_upd), 32'd0);
        model_reset();
        #1 rst = 1'b0;
        run(3);

        // invalid config picked up at the HOLD_LOW boundary
        set_cfg(16'd10, 16'd20, 16'd10, 24'd0, 16'd2);
        run_until(4, 10, 40);
        step = 16'd0;
        run(6);
        step = 16'd5;
        run(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
